// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : coin_dispenser
// Description : Refund coin dispenser FSM. Ejects quarters, then dimes, then
//               nickels. Each eject is a PULSE_LEN strobe followed by a
//               GAP_LEN gap. The optional Abort port and its logic exist only
//               when COIN_DISPENSER_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_dispenser #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Qnum,
  input  logic [3:0] Dnum,
  input  logic [3:0] Nnum,
  input  logic       HopperReady,
`ifdef COIN_DISPENSER_ABORT_EN
  input  logic       Abort,
`endif
  output logic       EjectQ,
  output logic       EjectD,
  output logic       EjectN,
  output logic [3:0] QLeft,
  output logic [3:0] DLeft,
  output logic [3:0] NLeft,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] COIN_Q     = 2'd0;
  localparam logic [1:0] COIN_D     = 2'd1;
  localparam logic [1:0] COIN_N     = 2'd2;
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_LEN - 1);

  state_t     state, state_n;
  logic [3:0] timer, timer_n;
  logic [1:0] sel, sel_n;
  logic [3:0] q_n, d_n, n_n;
  logic       abort_now;
  logic       abort_end;
`ifdef COIN_DISPENSER_ABORT_EN
  logic       abort_pend, abort_pend_n;
  assign abort_now = Abort;
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    sel_n     = sel;
    q_n       = QLeft;
    d_n       = DLeft;
    n_n       = NLeft;
    abort_end = 1'b0;
`ifdef COIN_DISPENSER_ABORT_EN
    abort_pend_n = abort_pend;
`endif
    case (state)
      IDLE: begin
`ifdef COIN_DISPENSER_ABORT_EN
        abort_pend_n = 1'b0;
`endif
        if (Start) begin
          q_n     = Qnum;
          d_n     = Dnum;
          n_n     = Nnum;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (abort_now) begin
          state_n = DONE;
        end else if (QLeft == 4'd0 && DLeft == 4'd0 && NLeft == 4'd0) begin
          state_n = DONE;
        end else if (HopperReady) begin
          state_n = EJECT;
          timer_n = PULSE_LAST;
          if (QLeft != 4'd0)      sel_n = COIN_Q;
          else if (DLeft != 4'd0) sel_n = COIN_D;
          else                    sel_n = COIN_N;
        end
      end
      EJECT: begin
`ifdef COIN_DISPENSER_ABORT_EN
        abort_pend_n = abort_pend | Abort;
        abort_end    = abort_pend_n;
`endif
        if (timer == 4'd0) begin
          case (sel)
            COIN_Q:  if (QLeft != 4'd0) q_n = QLeft - 4'd1;
            COIN_D:  if (DLeft != 4'd0) d_n = DLeft - 4'd1;
            default: if (NLeft != 4'd0) n_n = NLeft - 4'd1;
          endcase
          if (abort_end) begin
            state_n = DONE;
          end else begin
            state_n = GAP;
            timer_n = GAP_LAST;
          end
        end else begin
          timer_n = timer - 4'd1;
        end
      end
      GAP: begin
        if (abort_now)           state_n = DONE;
        else if (timer == 4'd0)  state_n = SELECT;
        else                     timer_n = timer - 4'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they align with state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      timer  <= 4'd0;
      sel    <= COIN_Q;
      QLeft  <= 4'd0;
      DLeft  <= 4'd0;
      NLeft  <= 4'd0;
      EjectQ <= 1'b0;
      EjectD <= 1'b0;
      EjectN <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
`ifdef COIN_DISPENSER_ABORT_EN
      abort_pend <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      sel    <= sel_n;
      QLeft  <= q_n;
      DLeft  <= d_n;
      NLeft  <= n_n;
      EjectQ <= (state_n == EJECT) && (sel_n == COIN_Q);
      EjectD <= (state_n == EJECT) && (sel_n == COIN_D);
      EjectN <= (state_n == EJECT) && (sel_n == COIN_N);
      Busy   <= (state_n == SELECT) || (state_n == EJECT) || (state_n == GAP);
      Done   <= (state_n == DONE);
`ifdef COIN_DISPENSER_ABORT_EN
      abort_pend <= abort_pend_n;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_dispenser
// Description : Directed self-checking bench for coin_dispenser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] qnum = 4'd0, dnum = 4'd0, nnum = 4'd0;
  logic       hopper = 1'b1;
`ifdef COIN_DISPENSER_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       ej_q, ej_d, ej_n, busy, done;
  logic [3:0] q_left, d_left, n_left;

  int n_checks = 0;
  int n_fail   = 0;
  int c        = 0;

  always #5 clk = ~clk;

  coin_dispenser #(.PULSE_LEN(4), .GAP_LEN(2)) dut (
    .Clock(clk), .Reset(rst), .Start(start),
    .Qnum(qnum), .Dnum(dnum), .Nnum(nnum), .HopperReady(hopper),
`ifdef COIN_DISPENSER_ABORT_EN
    .Abort(abort),
`endif
    .EjectQ(ej_q), .EjectD(ej_d), .EjectN(ej_n),
    .QLeft(q_left), .DLeft(d_left), .NLeft(n_left),
    .Busy(busy), .Done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] q, input logic [3:0] d, input logic [3:0] n);
    qnum = q; dnum = d; nnum = n; start = 1'b1; c = 0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", {ej_q, ej_d, ej_n, busy, done, q_left, d_left, n_left},
        32'd0);
    tick();

    // Q=1 D=1 N=0, hopper always ready
    hopper = 1'b1;
    launch(4'd1, 4'd1, 4'd0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      start = 1'b0;
      chk("t1_ejq",  ej_q, (c >= 2 && c <= 5));
      chk("t1_ejd",  ej_d, (c >= 9 && c <= 12));
      chk("t1_ejn",  ej_n, 0);
      chk("t1_done", done, (c == 16));
      chk("t1_busy", busy, (c >= 1 && c <= 15));
      if (c == 1)  chk("t1_left_c1", {q_left, d_left, n_left}, 12'h110);
      if (c == 6)  chk("t1_left_c6", {q_left, d_left, n_left}, 12'h010);
      if (c == 13) chk("t1_left_c13", {q_left, d_left, n_left}, 12'h000);
    end

    // All counts zero
    launch(4'd0, 4'd0, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      start = 1'b0;
      chk("t2_busy", busy, (c == 1));
      chk("t2_done", done, (c == 2));
      chk("t2_strobes", {ej_q, ej_d, ej_n}, 0);
    end

    // Two nickels, hopper stalls cycles 1-10
    hopper = 1'b0;
    launch(4'd0, 4'd0, 4'd2);
    for (int k = 1; k <= 27; k++) begin
      tick();
      start = 1'b0;
      if (c == 11) hopper = 1'b1;
      chk("t3_ejn", ej_n, ((c >= 12 && c <= 15) || (c >= 19 && c <= 22)));
      chk("t3_ejqd", {ej_q, ej_d}, 0);
      chk("t3_nleft", n_left, (c < 16) ? 2 : ((c < 23) ? 1 : 0));
      chk("t3_done", done, (c == 26));
      chk("t3_busy", busy, (c >= 1 && c <= 25));
    end

    // Reset mid-pulse; Start in the same cycle must be ignored
    launch(4'd3, 4'd0, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      start = 1'b0;
    end
    chk("t4_ejq_c4", ej_q, 1);
    rst = 1'b1; start = 1'b1; qnum = 4'd5;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("t4_after_rst", {ej_q, busy, done, q_left}, 0);
    tick();
    chk("t4_start_ignored", {busy, q_left}, 0);

    // Start re-pulsed while busy is ignored
    launch(4'd2, 4'd1, 4'd3);
    while (c < 3) begin
      tick();
      start = 1'b0;
    end
    start = 1'b1; qnum = 4'd9; dnum = 4'd7; nnum = 4'd5;
    tick();
    start = 1'b0;
    chk("t5_left_c4", {q_left, d_left, n_left}, 12'h213);
    tick();
    chk("t5_left_c5", {q_left, d_left, n_left}, 12'h213);
    tick();
    chk("t5_left_c6", {q_left, d_left, n_left}, 12'h113);
    while (!done && c < 100) tick();
    chk("t5_done_cycle", c, 44);
    chk("t5_final_left", {q_left, d_left, n_left}, 12'h000);
    tick();

`ifdef COIN_DISPENSER_ABORT_EN
    // Abort during the first quarter pulse
    launch(4'd3, 4'd0, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      start = 1'b0;
      abort = (c == 3);
      chk("t6_ejq", ej_q, (c >= 2 && c <= 5));
      chk("t6_done", done, (c == 6));
      chk("t6_busy", busy, (c >= 1 && c <= 5));
      if (c == 6) chk("t6_qleft", q_left, 2);
    end
    abort = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coin_dispenser.md
COIN_DISPENSER -- requirements
Module: coin_dispenser

Interface
REQ-001 Parameter PULSE_LEN, default 4, is the number of cycles each eject strobe stays high (legal range 1..15).
REQ-002 Parameter GAP_LEN, default 2, is the number of low cycles after each eject strobe (legal range 1..15).
REQ-003 Port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port Start, input, 1 bit: refund request, sampled only in IDLE.
REQ-006 Ports Qnum, Dnum, Nnum, input, 4 bits each: quarters, dimes and nickels to dispense (unsigned, 0..15).
REQ-007 Port HopperReady, input, 1 bit: the coin hopper can accept an eject.
REQ-008 Ports EjectQ, EjectD, EjectN, output, 1 bit each: eject strobes, at most one high at a time.
REQ-009 Ports QLeft, DLeft, NLeft, output, 4 bits each: coins still to be dispensed.
REQ-010 Port Busy, output, 1 bit: high in SELECT, EJECT and GAP.
REQ-011 Port Done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SELECT, EJECT, GAP and DONE.
REQ-013 In IDLE with Start=1, the block SHALL latch Qnum/Dnum/Nnum into QLeft/DLeft/NLeft and enter SELECT on the same edge.
REQ-014 Start SHALL be ignored in every state other than IDLE, and input count changes after the latch SHALL have no effect.
REQ-015 SELECT SHALL pick coins in priority order quarter > dime > nickel, taking the first type with a nonzero remaining count.
REQ-016 If a coin is selected and HopperReady=1, the FSM SHALL enter EJECT on the next edge.
REQ-017 If a coin is selected and HopperReady=0, the FSM SHALL stay in SELECT with all strobes low, indefinitely.
REQ-018 If all remaining counts are zero in SELECT, the FSM SHALL enter DONE.
REQ-019 In EJECT, the selected strobe SHALL be high for exactly PULSE_LEN consecutive cycles, and HopperReady SHALL be ignored once EJECT is entered.
REQ-020 On leaving EJECT, the selected remaining count SHALL decrement by 1 (never below 0), and the FSM SHALL enter GAP.
REQ-021 GAP SHALL last exactly GAP_LEN cycles with all strobes low, then return to SELECT.
REQ-022 The per-coin period with HopperReady held high SHALL be 1+PULSE_LEN+GAP_LEN cycles.
REQ-023 DONE SHALL last one cycle, with Done=1 and Busy=0, then return to IDLE; remaining counts SHALL hold their final values.
REQ-024 Start with all input counts zero SHALL give exactly one SELECT cycle, then the Done pulse.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 Reset=1 at a rising edge SHALL force IDLE, clear all strobes, Busy, Done and QLeft/DLeft/NLeft to 0, and clear the internal timers.
REQ-027 Reset SHALL take priority over Start and over the abort request, including mid-pulse, with the strobe low from the first post-reset cycle.

Configuration
REQ-028 With macro COIN_DISPENSER_ABORT_EN defined, the block SHALL add input port Abort (1 bit).
REQ-029 With that macro, Abort=1 in SELECT or GAP SHALL cause DONE on the next edge.
REQ-030 With that macro, Abort=1 in EJECT SHALL let the current strobe complete, decrement the count, and then enter DONE instead of GAP.
REQ-031 With that macro, remaining counts SHALL stay visible after an abort.
REQ-032 Without COIN_DISPENSER_ABORT_EN, the Abort port and its logic SHALL be absent, and every dispense SHALL run to completion.

Verification
REQ-033 The bench SHALL cover: defaults, Start at cycle 0 with Q=1,D=1,N=0, HopperReady=1 -> EjectQ high cycles 2-5, EjectD high cycles 9-12, Done=1 cycle 16, IDLE cycle 17.
REQ-034 The bench SHALL cover: Start with Q=D=N=0 -> Busy=1 cycle 1 only, Done=1 cycle 2, no strobes.
REQ-035 The bench SHALL cover: Q=0,D=0,N=2, HopperReady=0 during cycles 1-10 -> no strobe until cycle 11; EjectN high cycles 12-15 and 19-22; NLeft 2->1->0.
REQ-036 The bench SHALL cover: Reset=1 at cycle 4 of a Q=3 dispense -> EjectQ=0 from cycle 5, QLeft=0, Busy=0, and Start ignored in that cycle.
REQ-037 The bench SHALL cover: Start pulsed again at cycle 3 with different counts while Busy -> ignored; QLeft/DLeft/NLeft unchanged.
REQ-038 The bench SHALL cover, with COIN_DISPENSER_ABORT_EN: Q=3 and Abort at cycle 3 -> EjectQ completes cycles 2-5, QLeft=2, Done=1 cycle 6.
